memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words in the storage array.
REQ-002 Parameter ADDR_W, default 8, address bits used, log2(DEPTH).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port Buss  input  16  system bus value, loaded into MAR and MDR.
REQ-006 Port ldMAR  input  1  load MAR from Buss.
REQ-007 Port ldMDR  input  1  load MDR.
REQ-008 Port selMDR  input  1  MDR source select: 1 = memory read data, 0 = Buss.
REQ-009 Port memWE  input  1  write MDR into memory at address MAR.
REQ-010 Port mdrOut  output  16  current MDR register contents.

Function
REQ-011 Block SHALL contain a 16-bit MAR register, a 16-bit MDR register and a DEPTH x 16 storage array.
REQ-012 Rising clk edge with ldMAR=1 SHALL set MAR <= Buss; otherwise MAR holds.
REQ-013 Read data SHALL be combinational: rdata = array[MAR[ADDR_W-1:0]]; MAR bits 15..ADDR_W are ignored, so addresses wrap modulo DEPTH (0x0100 aliases 0x0000).
REQ-014 Rising clk edge with ldMDR=1 SHALL set MDR <= (selMDR ? rdata : Buss); otherwise MDR holds.
REQ-015 Rising clk edge with memWE=1 SHALL set array[MAR[ADDR_W-1:0]] <= MDR.
REQ-016 mdrOut SHALL equal MDR at all times, with no extra pipeline stage.
REQ-017 Read latency: MAR loaded at edge N, then ldMDR=1 with selMDR=1 at edge N+1 SHALL capture the addressed word, so mdrOut is valid after edge N+1.
REQ-018 Write latency: a write at edge N SHALL be visible on rdata right after edge N.
REQ-019 Every register update SHALL use pre-edge values. ldMAR with memWE on the same edge writes to the old MAR address.
REQ-020 ldMDR with memWE on the same edge SHALL write the old MDR value.
REQ-021 ldMDR with selMDR=1 and memWE on the same edge SHALL capture the pre-write (old) contents.
REQ-022 ldMAR, ldMDR and memWE SHALL be independent; any combination may be asserted at once.
REQ-023 No handshake; each operation completes in one edge and there is no busy or ready output.
REQ-024 Array contents SHALL initialise to 0x0000 at simulation time zero.

Reset
REQ-025 reset=0 SHALL immediately clear MAR and MDR to 0x0000, without waiting for clk, so mdrOut=0x0000.
REQ-026 While reset=0, ldMAR, ldMDR and memWE SHALL be ignored and no array write SHALL occur.
REQ-027 Array contents SHALL NOT be cleared by reset; they persist across reset.
REQ-028 Reset asserted mid-operation SHALL abort the pending load or write on that edge.
REQ-029 After reset is released, the first rising edge SHALL operate normally.

Verification
REQ-030 Store then load-back:
- Buss=0x0012, ldMAR=1, edge; then Buss=0xBEEF, ldMDR=1, selMDR=0, edge; then memWE=1, edge.
- Then Buss=0, ldMDR=1, selMDR=0, edge; then ldMDR=1, selMDR=1, edge.
- Required: mdrOut=0xBEEF.
REQ-031 Address wrap: write 0x1234 at MAR=0x0105, then read with MAR=0x0005 -> mdrOut=0x1234.
REQ-032 Same-edge write/read with MAR=0x0020 holding 0x1111 and MDR=0x2222:
- memWE=1 with ldMDR=1, selMDR=1 on one edge -> mdrOut=0x1111 and array[0x20]=0x2222.
REQ-033 Same-edge MAR change: MAR=0x0030, MDR=0x5555; memWE=1 with ldMAR=1, Buss=0x0031 -> array[0x30]=0x5555, array[0x31] unchanged.
REQ-034 Async reset mid-run: with MDR=0xBEEF, drive reset=0 between clk edges -> mdrOut=0x0000 before the next edge.
- A memWE=1 held during reset does not write.
- After reset is released, reading location 0x0012 still returns 0xBEEF.

Source files
------------

// File: rtl/memory.sv
// ----------------------------------------------------------------------------
// memory
//   Memory block with a memory address register (MAR) and a memory data
//   register (MDR) in front of a DEPTH x 16 word array.
//
//   - Read data comes straight out of the array, indexed by the low ADDR_W
//     bits of MAR. Addresses therefore wrap modulo DEPTH.
//   - On each rising clk edge, MAR, MDR and the array update independently.
//     Each update uses the values present before the edge.
//   - Reset clears MAR and MDR asynchronously. The array is never cleared.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous active-low reset (MAR/MDR only)
//   Buss    in  16   system bus, source for MAR and (selMDR=0) MDR
//   ldMAR   in   1   load MAR from Buss
//   ldMDR   in   1   load MDR from rdata (selMDR=1) or Buss (selMDR=0)
//   selMDR  in   1   MDR source select
//   memWE   in   1   write MDR into array[MAR]
//   mdrOut  out 16   current MDR contents
// ----------------------------------------------------------------------------
module memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Buss,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memWE,
    output logic [15:0] mdrOut
);

    logic [15:0] r_mar;
    logic [15:0] r_mdr;

    // The array powers up as all zeros and is deliberately kept out of the
    // reset domain, so stored data survives a reset.
    logic [15:0] r_mem [0:DEPTH-1] = '{default: 16'h0000};

    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_rdata;

    assign w_addr  = r_mar[ADDR_W-1:0];
    assign w_rdata = r_mem[w_addr];

    // The upper MAR bits are architecturally present but do not take part in
    // addressing. Folding them into a named sink keeps that explicit.
    generate
        if (ADDR_W < 16) begin : g_mar_hi
            logic w_unused_mar_hi;
            assign w_unused_mar_hi = ^r_mar[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mar <= 16'h0000;
            r_mdr <= 16'h0000;
        end else begin
            if (ldMAR)
                r_mar <= Buss;
            if (ldMDR)
                r_mdr <= selMDR ? w_rdata : Buss;
        end
    end

    // The write is qualified by reset being high on the edge, so a write
    // strobe held through reset is dropped. Because the array is updated
    // non-blocking, a same-edge MDR capture sees the old word, and the write
    // uses the old MAR and MDR values.
    always_ff @(posedge clk) begin
        if (reset && memWE)
            r_mem[w_addr] <= r_mdr;
    end

    assign mdrOut = r_mdr;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory block. All strobes are driven 1 time unit
// after a rising edge and cleared after the next one. Outputs are sampled at
// that same point, well away from the edge.
module tb_memory;

    logic        clk;
    logic        reset;
    logic [15:0] Buss;
    logic        ldMAR, ldMDR, selMDR, memWE;
    logic [15:0] mdrOut;

    int n_run  = 0;
    int n_fail = 0;

    memory #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .Buss   (Buss),
        .ldMAR  (ldMAR),
        .ldMDR  (ldMDR),
        .selMDR (selMDR),
        .memWE  (memWE),
        .mdrOut (mdrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then drop every strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        ldMAR  = 1'b0;
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        memWE  = 1'b0;
    endtask

    task automatic set_mar(input logic [15:0] a);
        Buss = a; ldMAR = 1'b1; tick();
    endtask

    task automatic set_mdr(input logic [15:0] v);
        Buss = v; ldMDR = 1'b1; selMDR = 1'b0; tick();
    endtask

    task automatic do_write();
        memWE = 1'b1; tick();
    endtask

    task automatic do_read();
        ldMDR = 1'b1; selMDR = 1'b1; tick();
    endtask

    task automatic rd(input logic [15:0] a);
        set_mar(a); do_read();
    endtask

    initial begin
        reset = 1'b0; Buss = 16'h0;
        ldMAR = 1'b0; ldMDR = 1'b0; selMDR = 1'b0; memWE = 1'b0;
        #12;
        chk("reset_mdr", mdrOut, 16'h0000);
        reset = 1'b1;
        tick();

        // Array starts as all zeros. Load MDR with a nonzero value first so
        // the read actually changes it.
        set_mdr(16'hFFFF);
        rd(16'h0055);
        chk("init_zero", mdrOut, 16'h0000);

        // Store, then load back.
        set_mar(16'h0012);
        set_mdr(16'hBEEF);
        chk("mdr_from_bus", mdrOut, 16'hBEEF);
        do_write();
        set_mdr(16'h0000);
        chk("mdr_cleared", mdrOut, 16'h0000);
        do_read();
        chk("store_load", mdrOut, 16'hBEEF);

        // With no strobes asserted, MDR holds its value.
        Buss = 16'h5A5A; tick(); tick();
        chk("mdr_hold", mdrOut, 16'hBEEF);

        // Address wrap: 0x0105 aliases 0x0005.
        set_mar(16'h0105);
        set_mdr(16'h1234);
        do_write();
        rd(16'h0005);
        chk("wrap_alias", mdrOut, 16'h1234);
        set_mdr(16'h0000);
        rd(16'h0105);
        chk("wrap_same", mdrOut, 16'h1234);

        // Same-edge write and read: the read captures the old contents.
        set_mar(16'h0020);
        set_mdr(16'h1111);
        do_write();
        set_mdr(16'h2222);
        memWE = 1'b1; ldMDR = 1'b1; selMDR = 1'b1; tick();
        chk("wr_rd_old", mdrOut, 16'h1111);
        do_read();
        chk("wr_rd_new", mdrOut, 16'h2222);

        // Same-edge MAR change: the write goes to the old address.
        set_mar(16'h0031);
        set_mdr(16'h7777);
        do_write();
        set_mar(16'h0030);
        set_mdr(16'h5555);
        Buss = 16'h0031; ldMAR = 1'b1; memWE = 1'b1; tick();
        do_read();
        chk("mar_chg_new", mdrOut, 16'h7777);
        rd(16'h0030);
        chk("mar_chg_old", mdrOut, 16'h5555);

        // Same-edge MDR load and write: the old MDR value is written.
        set_mar(16'h0040);
        set_mdr(16'hAAAA);
        Buss = 16'hBBBB; ldMDR = 1'b1; selMDR = 1'b0; memWE = 1'b1; tick();
        chk("mdr_chg_new", mdrOut, 16'hBBBB);
        do_read();
        chk("mdr_chg_wr", mdrOut, 16'hAAAA);

        // Preload address 0. Reset forces MAR to 0, so this location would
        // show any write that leaked through during reset.
        set_mar(16'h0000);
        set_mdr(16'h4321);
        do_write();

        // Async reset between edges, with MDR holding 0xBEEF.
        set_mar(16'h0050);
        set_mdr(16'hBEEF);
        chk("pre_reset", mdrOut, 16'hBEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_clr", mdrOut, 16'h0000);
        Buss = 16'h9999; ldMAR = 1'b1; ldMDR = 1'b1; memWE = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ignore", mdrOut, 16'h0000);
        ldMAR = 1'b0; ldMDR = 1'b0; memWE = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);

        // The first edge after reset behaves normally.
        set_mdr(16'h6A6A);
        chk("post_rst_ld", mdrOut, 16'h6A6A);
        rd(16'h0012);
        chk("persist_12", mdrOut, 16'hBEEF);
        rd(16'h0000);
        chk("rst_no_wr", mdrOut, 16'h4321);
        rd(16'h0040);
        chk("persist_40", mdrOut, 16'hAAAA);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
